// File: rtl/mux_8x2_sched.sv
// Round-robin scheduler that routes one of 8 requesters through the dual-bank mux_8x2.
// Optional forced release of long grants: define MUX_8X2_SCHED_TIMEOUT_EN.
module mux_8x2_sched #(
    parameter int MAX_HOLD = 15,
    parameter int CNT_W    = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] req,
    input  logic       done,
    output logic [7:0] gnt,
    output logic       sela,
    output logic       selb,
    output logic       e1,
    output logic       e2,
    output logic       busy,
    output logic       timeout
);
`ifdef MUX_8X2_SCHED_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    typedef enum logic {IDLE, GRANT} state_t;

    state_t           state_q, state_d;
    logic [7:0]       gnt_q, gnt_d;
    logic             sela_q, sela_d, selb_q, selb_d;
    logic             e1_q, e1_d, e2_q, e2_d;
    logic             busy_q, busy_d, timeout_q, timeout_d;
    logic [2:0]       ptr_q, ptr_d, idx_q, idx_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic       win_found;
    logic [2:0] win_idx;
    logic [2:0] cand;
    logic       rel, at_limit, force_rel;

    // First set request at or above ptr, wrapping 7 -> 0.
    always_comb begin
        win_found = 1'b0;
        win_idx   = ptr_q;
        cand      = '0;
        for (int k = 0; k < 8; k++) begin
            cand = ptr_q + 3'(k);
            if (!win_found && req[cand]) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
        end
    end

    assign rel       = done || !req[idx_q];
    assign at_limit  = (cnt_q == CNT_W'(MAX_HOLD - 1));
    assign force_rel = TO_EN && at_limit && !rel;

    always_comb begin
        state_d   = state_q;
        gnt_d     = gnt_q;
        sela_d    = sela_q;
        selb_d    = selb_q;
        e1_d      = e1_q;
        e2_d      = e2_q;
        busy_d    = busy_q;
        timeout_d = 1'b0;
        ptr_d     = ptr_q;
        idx_d     = idx_q;
        cnt_d     = cnt_q;
        case (state_q)
            IDLE: begin
                if (win_found) begin
                    state_d = GRANT;
                    idx_d   = win_idx;
                    gnt_d   = 8'b1 << win_idx;
                    sela_d  = win_idx[0];
                    selb_d  = win_idx[1];
                    e1_d    = !win_idx[2];
                    e2_d    = win_idx[2];
                    busy_d  = 1'b1;
                    cnt_d   = '0;
                end
            end
            GRANT: begin
                cnt_d = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;
                // Release drops enables for a full cycle before the next winner is routed.
                if (rel || force_rel) begin
                    state_d   = IDLE;
                    gnt_d     = '0;
                    e1_d      = 1'b0;
                    e2_d      = 1'b0;
                    busy_d    = 1'b0;
                    ptr_d     = idx_q + 3'd1;
                    timeout_d = force_rel;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            gnt_q     <= '0;
            sela_q    <= 1'b0;
            selb_q    <= 1'b0;
            e1_q      <= 1'b0;
            e2_q      <= 1'b0;
            busy_q    <= 1'b0;
            timeout_q <= 1'b0;
            ptr_q     <= '0;
            idx_q     <= '0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            gnt_q     <= gnt_d;
            sela_q    <= sela_d;
            selb_q    <= selb_d;
            e1_q      <= e1_d;
            e2_q      <= e2_d;
            busy_q    <= busy_d;
            timeout_q <= timeout_d;
            ptr_q     <= ptr_d;
            idx_q     <= idx_d;
            cnt_q     <= cnt_d;
        end
    end

    assign gnt     = gnt_q;
    assign sela    = sela_q;
    assign selb    = selb_q;
    assign e1      = e1_q;
    assign e2      = e2_q;
    assign busy    = busy_q;
    assign timeout = timeout_q;
endmodule

// File: doc/mux_8x2_sched.md
Name: mux_8x2_sched

Overview:
- Round-robin scheduler that shares the dual-bank 8-input mux_8x2 datapath among 8 requesters.
- Requester i maps to mux input in[i]. Inputs 0-3 form bank 1 (output y1, enable e1); inputs 4-7 form bank 2 (output y2, enable e2).
- The block arbitrates, drives sela/selb/e1/e2 to route the winner, holds the path until the winner releases it, then re-arbitrates.
- Sits directly in front of mux_8x2; its outputs connect 1:1 to the mux select and enable pins.

Parameters:
- MAX_HOLD, 15: maximum grant length in cycles (range 1..255). Used only when TIMEOUT_EN is defined.
- CNT_W, 8: width of the hold counter. Must satisfy 2^CNT_W > MAX_HOLD.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- req  input  8  request vector; bit i = requester i wants the mux
- done  input  1  current holder releases the path (single-cycle pulse)
- gnt  output  8  one-hot grant, registered
- sela  output  1  mux select LSB = grant index bit 0
- selb  output  1  mux select MSB = grant index bit 1
- e1  output  1  bank 1 enable = grant active and index bit 2 = 0
- e2  output  1  bank 2 enable = grant active and index bit 2 = 1
- busy  output  1  high while in GRANT
- timeout  output  1  one-cycle pulse when a grant is force-revoked

Behaviour:
- Reset (asynchronous, takes effect immediately, including mid-grant): state=IDLE; gnt=0, sela=0, selb=0, e1=0, e2=0, busy=0, timeout=0; round-robin pointer ptr=0; hold counter=0.
- All outputs are registered. e1 and e2 are never both high. gnt is zero or one-hot, and its index always equals {e2, selb, sela} whenever a grant is active.
- States: IDLE, GRANT.
- IDLE:
  - If req != 0, select the first set bit searching upward from ptr, wrapping 7->0.
  - Next edge: enter GRANT; set gnt, sela, selb, e1/e2 and busy=1; clear counter.
  - Latency from a sampled req to a visible grant is 1 cycle.
  - done is ignored in IDLE.
- GRANT:
  - sela/selb/e1/e2/gnt are held stable for the whole grant.
  - Release when the sampled done=1, or when req[idx] has dropped to 0.
  - On release, the next edge goes to IDLE: gnt=0, e1=e2=0, busy=0, ptr=(idx+1) mod 8.
  - sela/selb keep their last value after release (don't-care while both enables are 0).
  - Requests arriving during GRANT are only evaluated after returning to IDLE.
- Gap rule: at least one IDLE cycle (enables low) between consecutive grants, even with continuous requests. This gives a break-before-make on the mux.
- Wrap-around:
  - ptr=7 searches 7,0,1,...
  - A lone requester re-wins every 2 cycles (grant, idle, grant).
- Simultaneous events:
  - done together with req[idx] dropping: a single release.
  - done together with the timeout condition: treated as a normal release, timeout stays 0.
- Counter: increments every GRANT cycle and saturates at 2^CNT_W-1. It has no effect unless TIMEOUT_EN is defined.

Optional Feature:
- Macro: MUX_8X2_SCHED_TIMEOUT_EN.
- Defined:
  - In GRANT, if the counter equals MAX_HOLD-1 and no release condition is present, the next edge force-releases the grant exactly as a normal release would.
  - timeout pulses high for that one cycle (coincident with entering IDLE).
  - ptr advances past the holder, so the holder cannot monopolise the mux.
  - Resulting maximum grant length is MAX_HOLD cycles.
- Not defined:
  - A grant is held until done or the holder's req drops.
  - timeout is tied to 0.

Test Plan:
- Reset, then req=8'h00 for 5 cycles -> gnt=0, e1=e2=0, busy=0 throughout. Assert rst mid-grant -> all outputs 0 without waiting for a clock edge.
- req=8'h04 -> 1 cycle later gnt=8'h04, selb=1, sela=0, e1=1, e2=0. Pulse done -> next cycle all enables 0, busy=0.
- req=8'hFF held, done pulsed each grant cycle -> grant order 0,1,...,7,0 with one idle cycle between grants; e2=1 exactly for indices 4-7.
- req=8'h81 with ptr=7 (after granting 6) -> 7 granted first (sela=selb=1, e2=1), then 0 (e1=1, sela=selb=0).
- Holder 5 drops req[5] without done -> released next cycle. A simultaneous req[2] is granted only after the idle cycle.
- With MUX_8X2_SCHED_TIMEOUT_EN and MAX_HOLD=4, req=8'h08 held and done never asserted -> gnt=8'h08 for exactly 4 cycles, timeout=1 for 1 cycle, then regranted. Without the macro, the grant persists more than 20 cycles and timeout stays 0.
